// File: rtl/taylor_trig_engine.sv
// taylor_trig_engine: sequenced fixed-point Taylor series for cos(x) / sin(x) with early termination
module taylor_trig_engine #(
  parameter int W = 16,
  parameter int FRAC = 8,
  parameter int N_TERMS = 8,
  parameter int CW = $clog2(N_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  eps_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [CW-1:0] terms_used,
  output logic          sat
);
  typedef enum logic [2:0] {IDLE, SQR, MUL1, MUL2, ACC, DONE} state_t;
  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  state_t state, state_n;
  logic [W-1:0] x, x2, eps, term, res, coef, a, b, p, acc;
  logic [2*W-1:0] full, sh;
  logic [CW-1:0] k;
  logic m, ovf, stop;
  logic [W-1:0] rom_cos [2**CW];
  logic [W-1:0] rom_sin [2**CW];
  function automatic logic [W-1:0] coef_of(input int n, input int s);
    int d;
    int v;
    d = s != 0 ? (2*n) * (2*n + 1) : (2*n - 1) * (2*n);
    v = d <= 0 ? 1 : (1 << FRAC) / d;
    v = v == 0 ? 1 : v;
    return W'(v);
  endfunction
  for (genvar i = 0; i < 2**CW; i++) begin : g_rom
    localparam logic [W-1:0] CC = coef_of(i, 0);
    localparam logic [W-1:0] CS = coef_of(i, 1);
    assign rom_cos[i] = CC;
    assign rom_sin[i] = CS;
  end
  // One shared multiplier; operands chosen by the current step
  always_comb begin
    coef = m ? rom_sin[k] : rom_cos[k];
    a = state == SQR ? x : term;
    b = state == SQR ? x : state == MUL1 ? x2 : coef;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sh = full >> FRAC;
    ovf = |sh[2*W-1:W];
    p = ovf ? '1 : sh[W-1:0];
    acc = k[0] ? res - term : res + term;
    stop = term < eps || term == '0 || k == CW'(N_TERMS);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? SQR : IDLE;
      SQR:  state_n = MUL1;
      MUL1: state_n = MUL2;
      MUL2: state_n = ACC;
      ACC:  state_n = stop ? DONE : MUL1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      x2 <= '0;
      eps <= '0;
      term <= '0;
      res <= '0;
      k <= '0;
      m <= 1'b0;
      sat <= 1'b0;
      result <= '0;
      terms_used <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x <= x_in;
          m <= mode;
          eps <= eps_in;
          k <= CW'(1);
          sat <= 1'b0;
          term <= mode ? x_in : ONE;
          res <= mode ? x_in : ONE;
        end
        SQR: begin
          x2 <= p;
          sat <= sat | ovf;
        end
        MUL1, MUL2: begin
          term <= p;
          sat <= sat | ovf;
        end
        ACC: begin
          res <= acc;
          if (stop) begin
            result <= acc;
            terms_used <= k;
          end else k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_taylor_trig_engine.sv
// tb_taylor_trig_engine: directed vectors with hand-computed cos/sin sums, latency and handshake checks
module tb_taylor_trig_engine;
  localparam int W = 16;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] eps_in = '0;
  logic busy, done, sat;
  logic [W-1:0] result;
  logic [CW-1:0] terms_used;
  int vectors = 0;
  int errs = 0;
  taylor_trig_engine #(.W(W), .FRAC(8), .N_TERMS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .x_in(x_in), .eps_in(eps_in),
    .busy(busy), .done(done), .result(result), .terms_used(terms_used), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  // Starts at a negedge in IDLE and returns at the negedge after DONE (back in IDLE)
  task automatic run(input string tag, input logic md, input logic [W-1:0] x, input logic [W-1:0] e,
                     input int er, input int et, input int es, input int el, input bit poke);
    int cyc = 0;
    start = 1'b1;
    mode = md;
    x_in = x;
    eps_in = e;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 1);
    while (!done && cyc < 100) begin
      start = poke && cyc == 3;
      if (poke && cyc == 3) x_in = '0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"}, cyc, el);
    chk({tag, " result"}, 32'(result), er);
    chk({tag, " terms"}, 32'(terms_used), et);
    chk({tag, " sat"}, 32'(sat), es);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done width"}, 32'(done), 0);
    chk({tag, " busy end"}, 32'(busy), 0);
    chk({tag, " result held"}, 32'(result), er);
  endtask
  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst result", 32'(result), 0);
    chk("rst terms", 32'(terms_used), 0);
    chk("rst sat", 32'(sat), 0);
    rst = 1'b0;
    @(negedge clk);
    run("cos0", 1'b0, 16'd0, 16'd0, 256, 1, 0, 4, 1'b0);
    run("cos1", 1'b0, 16'd256, 16'd0, 138, 3, 0, 10, 1'b0);
    run("early", 1'b0, 16'd256, 16'd16, 138, 2, 0, 7, 1'b0);
    run("sin1", 1'b1, 16'd256, 16'd0, 215, 3, 0, 10, 1'b0);
    run("satx", 1'b0, 16'hFFFF, 16'hFFFF, 33025, 1, 1, 4, 1'b0);
    run("hs", 1'b0, 16'd256, 16'd0, 138, 3, 0, 10, 1'b1);
    run("hs2", 1'b1, 16'd256, 16'd0, 215, 3, 0, 10, 1'b0);
    start = 1'b1;
    mode = 1'b0;
    x_in = 16'd256;
    eps_in = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(done), 0);
    chk("mid rst result", 32'(result), 0);
    chk("mid rst terms", 32'(terms_used), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("no done after rst", 32'(seen), 0);
    run("cos1 post", 1'b0, 16'd256, 16'd0, 138, 3, 0, 10, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
